// File: rtl/iiitb_sdm_pkg.sv
// rtl/iiitb_sdm_pkg.sv - shared report-state enum and default sizing for the 1010 match monitor
package iiitb_sdm_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rep_state_t;

  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_CNT_W   = 5;
  localparam int DEF_IRQ_THR = 4;

endpackage

// File: rtl/iiitb_win_ctr.sv
// rtl/iiitb_win_ctr.sv - window bit counter and saturating match counter with sticky overflow
// Optional threshold interrupt under IIITB_SDM_IRQ_EN.
module iiitb_win_ctr
  import iiitb_sdm_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W
`ifdef IIITB_SDM_IRQ_EN
  ,
  parameter int IRQ_THR = DEF_IRQ_THR
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_vld,
  input  logic             y_in,
  output logic             win_done,
  output logic [CNT_W-1:0] fin_count,
  output logic             fin_ovf
`ifdef IIITB_SDM_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int              WW   = $clog2(WIN_LEN);
  localparam logic [WW-1:0]   LAST = WW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] SAT = '1;

  logic [WW-1:0]    win_cnt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ovf, ovf_nxt, inc, at_sat;

  // fin_* already include the current bit, so the final bit of a window lands in its report
  always_comb begin
    inc       = bit_vld & y_in;
    at_sat    = (count == SAT);
    win_done  = bit_vld && (win_cnt == LAST);
    fin_count = (inc && !at_sat) ? count + CNT_W'(1) : count;
    fin_ovf   = ovf | (inc & at_sat);
    count_nxt = win_done ? '0 : fin_count;
    ovf_nxt   = win_done ? 1'b0 : fin_ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (bit_vld) win_cnt <= win_done ? '0 : win_cnt + WW'(1);
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

`ifdef IIITB_SDM_IRQ_EN
  logic [31:0] count_ext;
  assign count_ext = 32'(count_nxt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= (count_ext >= 32'(IRQ_THR));
  end
`endif

endmodule

// File: rtl/iiitb_sdm_mon.sv
// rtl/iiitb_sdm_mon.sv - windowed 1010-match monitor with a single-entry report slot
// Optional irq port and threshold logic under IIITB_SDM_IRQ_EN.
module iiitb_sdm_mon
  import iiitb_sdm_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W
`ifdef IIITB_SDM_IRQ_EN
  ,
  parameter int IRQ_THR = DEF_IRQ_THR
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_vld,
  input  logic             y_in,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [CNT_W-1:0] rep_count,
  output logic             rep_ovf,
  output logic             rep_drop
`ifdef IIITB_SDM_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic             win_done, fin_ovf;
  logic [CNT_W-1:0] fin_count;
  rep_state_t       state_q, state_d;
  logic             load, drop;

  iiitb_win_ctr #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
`ifdef IIITB_SDM_IRQ_EN
    ,
    .IRQ_THR (IRQ_THR)
`endif
  ) u_win_ctr (
    .clk       (clk),
    .reset     (reset),
    .bit_vld   (bit_vld),
    .y_in      (y_in),
    .win_done  (win_done),
    .fin_count (fin_count),
    .fin_ovf   (fin_ovf)
`ifdef IIITB_SDM_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  // A completion while full replaces the slot only if the old report leaves this same cycle
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (win_done) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (win_done) begin
          if (rep_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (rep_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      rep_count <= '0;
      rep_ovf   <= 1'b0;
      rep_drop  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rep_drop <= drop;
      if (load) begin
        rep_count <= fin_count;
        rep_ovf   <= fin_ovf;
      end
    end
  end

  assign rep_valid = (state_q == FULL);

endmodule

// File: tb/tb_iiitb_sdm_mon.sv
// tb/tb_iiitb_sdm_mon.sv - directed-vector bench for iiitb_sdm_mon (default and CNT_W=2 instances)
// Threshold interrupt checks compile in with IIITB_SDM_IRQ_EN.
module tb_iiitb_sdm_mon;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_vld = 1'b0;
  logic       y_in = 1'b0;
  logic       rep_ready = 1'b0;
  logic       rep_valid, rep_ovf, rep_drop;
  logic [4:0] rep_count;
  logic       rep_valid2, rep_ovf2, rep_drop2;
  logic [1:0] rep_count2;
`ifdef IIITB_SDM_IRQ_EN
  logic       irq, irq2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  iiitb_sdm_mon dut (
    .clk       (clk),
    .reset     (reset),
    .bit_vld   (bit_vld),
    .y_in      (y_in),
    .rep_valid (rep_valid),
    .rep_ready (rep_ready),
    .rep_count (rep_count),
    .rep_ovf   (rep_ovf),
    .rep_drop  (rep_drop)
`ifdef IIITB_SDM_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  iiitb_sdm_mon #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .bit_vld   (bit_vld),
    .y_in      (y_in),
    .rep_valid (rep_valid2),
    .rep_ready (rep_ready),
    .rep_count (rep_count2),
    .rep_ovf   (rep_ovf2),
    .rep_drop  (rep_drop2)
`ifdef IIITB_SDM_IRQ_EN
    ,
    .irq       (irq2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present one input cycle, then settle just past the edge for sampling
  task automatic step(input logic v, input logic y);
    bit_vld = v;
    y_in    = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(rep_valid), 0);
    chk("rst_count", 32'(rep_count), 0);
    chk("rst_ovf",   32'(rep_ovf),   0);
    chk("rst_drop",  32'(rep_drop),  0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Matches on bits 4,6,...,16 -> 7
    for (int b = 1; b <= 16; b++) begin
      step(1'b1, (b >= 4) && (b % 2 == 0));
      if (b == 15) chk("w1_valid_early", 32'(rep_valid), 0);
    end
    chk("w1_valid",  32'(rep_valid),  1);
    chk("w1_count",  32'(rep_count),  7);
    chk("w1_ovf",    32'(rep_ovf),    0);
    chk("w1_count2", 32'(rep_count2), 3);
    chk("w1_ovf2",   32'(rep_ovf2),   1);
    rep_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("w1_accept", 32'(rep_valid), 0);
    rep_ready = 1'b0;

    // Five matches: saturation on the narrow instance
    for (int b = 1; b <= 16; b++) step(1'b1, b <= 5);
    chk("w2_count",  32'(rep_count),  5);
    chk("w2_ovf",    32'(rep_ovf),    0);
    chk("w2_count2", 32'(rep_count2), 3);
    chk("w2_ovf2",   32'(rep_ovf2),   1);

    // Second completion with no acceptance is dropped
    for (int b = 1; b <= 16; b++) begin
      step(1'b1, b <= 2);
      if (b == 15) chk("w3_drop_early", 32'(rep_drop), 0);
    end
    chk("w3_valid", 32'(rep_valid), 1);
    chk("w3_held",  32'(rep_count), 5);
    chk("w3_drop",  32'(rep_drop),  1);
    step(1'b0, 1'b0);
    chk("w3_drop_end", 32'(rep_drop),  0);
    chk("w3_held2",    32'(rep_count), 5);

    // Acceptance coincides with the next completion
    for (int b = 1; b <= 16; b++) begin
      rep_ready = (b == 16);
      step(1'b1, b <= 3);
    end
    chk("w4_valid", 32'(rep_valid), 1);
    chk("w4_count", 32'(rep_count), 3);
    chk("w4_drop",  32'(rep_drop),  0);
    step(1'b0, 1'b0);
    chk("w4_accept", 32'(rep_valid), 0);
    rep_ready = 1'b0;

    // bit_vld toggling, y_in held high: 16 valid bits span 31 cycles
    for (int i = 0; i <= 30; i++) begin
      step(i % 2 == 0, 1'b1);
      if (i == 29) chk("w5_valid_early", 32'(rep_valid), 0);
    end
    chk("w5_valid",  32'(rep_valid),  1);
    chk("w5_count",  32'(rep_count),  16);
    chk("w5_ovf",    32'(rep_ovf),    0);
    chk("w5_count2", 32'(rep_count2), 3);

    // Partial window of 8 matches with a report pending, then reset during bit 9
    for (int b = 1; b <= 8; b++) begin
      step(1'b1, 1'b1);
`ifdef IIITB_SDM_IRQ_EN
      if (b == 3) chk("irq_pre", 32'(irq), 0);
      if (b == 4) chk("irq_rise", 32'(irq), 1);
`endif
    end
    bit_vld = 1'b1;
    y_in    = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rep_valid), 0);
    chk("mid_rst_count", 32'(rep_count), 0);
    chk("mid_rst_ovf",   32'(rep_ovf),   0);
    chk("mid_rst_drop",  32'(rep_drop),  0);
`ifdef IIITB_SDM_IRQ_EN
    chk("mid_rst_irq", 32'(irq), 0);
`endif
    bit_vld = 1'b0;
    y_in    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fresh window: matches on bits 3,6,9,12
    for (int b = 1; b <= 16; b++) begin
      step(1'b1, (b % 3 == 0) && (b <= 12));
      if (b == 15) chk("w6_valid_early", 32'(rep_valid), 0);
`ifdef IIITB_SDM_IRQ_EN
      if (b == 11) chk("w6_irq_pre",  32'(irq), 0);
      if (b == 12) chk("w6_irq_rise", 32'(irq), 1);
      if (b == 15) chk("w6_irq_hold", 32'(irq), 1);
`endif
    end
    chk("w6_valid", 32'(rep_valid), 1);
    chk("w6_count", 32'(rep_count), 4);
    chk("w6_ovf",   32'(rep_ovf),   0);
`ifdef IIITB_SDM_IRQ_EN
    chk("w6_irq_clr", 32'(irq), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
